// File: rtl/bus_pkg.sv
// Shared types and default decode constants for the wait-state bus controller.
// The reserved prefix is only an error region when BUS_ERR_EN is defined.
package bus_pkg;

    typedef enum logic [1:0] {
        REG_MEM,
        REG_IO,
        REG_VR,
        REG_ERR
    } region_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_DONE
    } state_e;

    localparam logic [2:0] IO_PREFIX_D  = 3'b101;
    localparam logic [2:0] VR_PREFIX_D  = 3'b110;
    localparam logic [2:0] ERR_PREFIX   = 3'b111;

endpackage

// File: rtl/bus_region_decode.sv
// Combinational region decode: top-3-bit address prefix to target region and wait-state count.
// With BUS_ERR_EN defined, the reserved prefix and read+write collisions map to REG_ERR.
module bus_region_decode
    import bus_pkg::*;
#(
    parameter logic [2:0]  IO_PREFIX = IO_PREFIX_D,
    parameter logic [2:0]  VR_PREFIX = VR_PREFIX_D,
    parameter int unsigned MEM_WS    = 0,
    parameter int unsigned IO_WS     = 2,
    parameter int unsigned VR_WS     = 1,
    parameter int unsigned WS_W      = 4
) (
    input  logic [2:0]      prefix,
    input  logic            both_req,
    output region_e         region,
    output logic [WS_W-1:0] ws_load
);

    always_comb begin
        region = REG_MEM;
        if (prefix == IO_PREFIX) begin
            region = REG_IO;
        end else if (prefix == VR_PREFIX) begin
            region = REG_VR;
        end
`ifdef BUS_ERR_EN
        if ((prefix == ERR_PREFIX) || both_req) begin
            region = REG_ERR;
        end
`endif
    end

`ifndef BUS_ERR_EN
    logic unused_both_req;
    assign unused_both_req = both_req;
`endif

    always_comb begin
        ws_load = '0;
        unique case (region)
            REG_MEM: ws_load = MEM_WS[WS_W-1:0];
            REG_IO:  ws_load = IO_WS[WS_W-1:0];
            REG_VR:  ws_load = VR_WS[WS_W-1:0];
            default: ws_load = '0;
        endcase
    end

endmodule

// File: rtl/bus_ctrl_ws.sv
// Registered memory/IO/VRAM bus controller with per-region wait states and four-phase handshake.
// Optional macro BUS_ERR_EN enables the reserved-prefix / collision error response on bus_err.
module bus_ctrl_ws
    import bus_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter logic [2:0]  IO_PREFIX = IO_PREFIX_D,
    parameter logic [2:0]  VR_PREFIX = VR_PREFIX_D,
    parameter int unsigned MEM_WS    = 0,
    parameter int unsigned IO_WS     = 2,
    parameter int unsigned VR_WS     = 1,
    parameter int unsigned WS_W      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr_bus,
    input  logic              m_read,
    input  logic              m_write,
    output logic              write,
    output logic              io_rdn,
    output logic              io_wrn,
    output logic              wvram,
    output logic              rvram,
    output logic              ready,
    output logic              busy,
    output logic              bus_err
);

    localparam logic [WS_W-1:0] CNT_ONE = {{(WS_W-1){1'b0}}, 1'b1};

    logic            req;
    logic [2:0]      prefix;
    region_e         dec_region;
    logic [WS_W-1:0] ws_load;

    state_e          state;
    region_e         region_q;
    logic            op_wr_q;
    logic [WS_W-1:0] cnt;

    assign req    = m_read | m_write;
    assign prefix = addr_bus[ADDR_W-1:ADDR_W-3];

    // Only the region prefix is decoded; the rest of the address goes straight to the targets.
    logic unused_addr;
    assign unused_addr = ^addr_bus[ADDR_W-4:0];

    bus_region_decode #(
        .IO_PREFIX (IO_PREFIX),
        .VR_PREFIX (VR_PREFIX),
        .MEM_WS    (MEM_WS),
        .IO_WS     (IO_WS),
        .VR_WS     (VR_WS),
        .WS_W      (WS_W)
    ) u_decode (
        .prefix   (prefix),
        .both_req (m_read & m_write),
        .region   (dec_region),
        .ws_load  (ws_load)
    );

`ifdef BUS_ERR_EN
    logic bus_err_q;
    assign bus_err = bus_err_q;
`else
    assign bus_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            region_q <= REG_MEM;
            op_wr_q  <= 1'b0;
            cnt      <= '0;
            write    <= 1'b0;
            io_rdn   <= 1'b1;
            io_wrn   <= 1'b1;
            wvram    <= 1'b0;
            rvram    <= 1'b0;
            ready    <= 1'b0;
            busy     <= 1'b0;
`ifdef BUS_ERR_EN
            bus_err_q <= 1'b0;
`endif
        end else begin
            // Strobes and ready are pulses: inactive unless re-asserted below.
            write  <= 1'b0;
            io_rdn <= 1'b1;
            io_wrn <= 1'b1;
            wvram  <= 1'b0;
            rvram  <= 1'b0;
            ready  <= 1'b0;
`ifdef BUS_ERR_EN
            bus_err_q <= 1'b0;
`endif
            unique case (state)
                S_IDLE: begin
                    if (req) begin
                        region_q <= dec_region;
                        op_wr_q  <= m_write;
                        cnt      <= ws_load;
                        busy     <= 1'b1;
`ifdef BUS_ERR_EN
                        if (dec_region == REG_ERR) begin
                            ready     <= 1'b1;
                            bus_err_q <= 1'b1;
                            state     <= S_DONE;
                        end else begin
                            state <= S_ACCESS;
                        end
`else
                        state <= S_ACCESS;
`endif
                    end
                end
                S_ACCESS: begin
                    write  <= (region_q == REG_MEM) && op_wr_q;
                    io_rdn <= !((region_q == REG_IO) && !op_wr_q);
                    io_wrn <= !((region_q == REG_IO) && op_wr_q);
                    wvram  <= (region_q == REG_VR) && op_wr_q;
                    rvram  <= (region_q == REG_VR) && !op_wr_q;
                    if (cnt == '0) begin
                        ready <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                S_DONE: begin
                    // Hold off until the CPU drops its request so a held request is not re-served.
                    if (!req) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
